// File: rtl/grn_line_writer.sv
// Consumer end of the GRN result-line handshake: acknowledges producer lines,
// buffers them and streams them to the host write channel at consecutive line addresses.
module grn_line_writer #(
  parameter int LINE_W     = 512,
  parameter int ADDR_W     = 42,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_write,
  input  logic [LINE_W-1:0] line_in,
  input  logic              finish,
  output logic              ack_write,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_almost_full,
  input  logic              wr_rsp_valid,
  output logic [31:0]       lines_written,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] issued_cnt;
  logic [LINE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [OUT_W-1:0]  outst;

  logic active;
  logic accept;
  logic issue;
  logic rsp_take;
  logic req_pending;

  // The ack cycle never accepts, so a producer still holding req during ack is not re-captured.
  always_comb begin
    active      = (state == RUN) || (state == DRAIN);
    req_pending = req_write && !ack_write;
    accept      = active && req_pending && (fifo_cnt < CNT_W'(FIFO_DEPTH));
    issue       = active && (fifo_cnt != '0) && !wr_almost_full &&
                  (outst < OUT_W'(MAX_OUTST));
    rsp_take    = wr_rsp_valid && (outst != '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DRAIN;
      DRAIN:   if ((fifo_cnt == '0) && (outst == '0) && !req_pending) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      base_q        <= '0;
      issued_cnt    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      outst         <= '0;
      ack_write     <= 1'b0;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      lines_written <= '0;
    end else begin
      state     <= state_nxt;
      ack_write <= accept;
      wr_valid  <= issue;

      if ((state == IDLE) && start) begin
        base_q     <= base_addr;
        issued_cnt <= '0;
      end

      if (accept) wr_ptr <= wr_ptr + 1'b1;

      if (issue) begin
        rd_ptr     <= rd_ptr + 1'b1;
        wr_data    <= fifo_mem[rd_ptr];
        wr_addr    <= base_q + issued_cnt;
        issued_cnt <= issued_cnt + 1'b1;
      end

      case ({accept, issue})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      // A response and an issue in the same cycle cancel out.
      case ({issue, rsp_take})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase

      if (rsp_take) lines_written <= lines_written + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= line_in;
  end

endmodule

// File: tb/tb_grn_line_writer.sv
// Bench for grn_line_writer: vector table of whole runs plus hand-written corner sequences,
// every memory write checked against a queue of expected address/data pairs.
module tb_grn_line_writer;

  localparam int LINE_W = 512;
  localparam int ADDR_W = 42;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              req_write = 1'b0;
  logic [LINE_W-1:0] line_in = '0;
  logic              finish = 1'b0;
  logic              ack_write;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;
  logic              wr_almost_full = 1'b0;
  logic              wr_rsp_valid;
  logic [31:0]       lines_written;
  logic              done;

  logic rsp_auto_pulse = 1'b0;
  logic rsp_manual = 1'b0;
  assign wr_rsp_valid = rsp_auto_pulse | rsp_manual;

  grn_line_writer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .req_write      (req_write),
    .line_in        (line_in),
    .finish         (finish),
    .ack_write      (ack_write),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_almost_full (wr_almost_full),
    .wr_rsp_valid   (wr_rsp_valid),
    .lines_written  (lines_written),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  wr_exp_t mon_e;

  int assert_cnt = 0;
  int fail_cnt = 0;
  int ack_cnt = 0;
  int wv_cnt = 0;
  int rsp_pending = 0;
  bit rsp_auto = 1'b0;
  logic ack_prev = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard and auto-responder: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst) begin
      rsp_pending    = 0;
      rsp_auto_pulse = 1'b0;
      ack_prev       = 1'b0;
    end else begin
      if (ack_write) begin
        ack_cnt++;
        check_output("ack_single_cycle", 64'(ack_prev), 64'd0);
      end
      ack_prev = ack_write;
      if (wr_valid) begin
        wv_cnt++;
        assert_cnt++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h, required no write", wr_addr);
        end else begin
          mon_e = exp_q.pop_front();
          if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
            fail_cnt++;
            $display("[TB] FAIL write_contents: got addr 0x%0h data 0x%0h, required addr 0x%0h data 0x%0h",
                     wr_addr, wr_data, mon_e.addr, mon_e.data);
          end
        end
        if (rsp_auto) rsp_pending++;
      end
      if (rsp_pending > 0) begin
        rsp_auto_pulse = 1'b1;
        rsp_pending--;
      end else begin
        rsp_auto_pulse = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] random_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    rst            = 1'b0;
    start          = 1'b0;
    req_write      = 1'b0;
    finish         = 1'b0;
    wr_almost_full = 1'b0;
    rsp_manual     = 1'b0;
    rsp_auto       = 1'b0;
    exp_q.delete();
    repeat (3) step();
    rst = 1'b1;
    step();
  endtask

  task automatic start_block(input logic [ADDR_W-1:0] base);
    base_addr = base;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Offers one line and holds req until the ack pulse is seen.
  task automatic apply_stimulus(input logic [LINE_W-1:0] d, input logic [ADDR_W-1:0] a);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
    req_write = 1'b1;
    line_in   = d;
    for (int t = 0; t < 300; t++) begin
      step();
      if (ack_write) begin
        req_write = 1'b0;
        return;
      end
    end
    check_output("ack_timeout", 64'(ack_write), 64'd1);
    req_write = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int cyc;
    cyc = 0;
    while (!done && cyc < max_cycles) begin
      step();
      cyc++;
    end
    check_output("done_reached", 64'(done), 64'd1);
  endtask

  task automatic wait_writes(input int target, input int max_cycles);
    int cyc;
    cyc = 0;
    while (wv_cnt < target && cyc < max_cycles) begin
      step();
      cyc++;
    end
    check_output("writes_reached", 64'(wv_cnt), 64'(target));
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                n_lines;
    logic [ADDR_W-1:0] exp_last_addr;
    logic [31:0]       exp_lines;
    int                max_done_cycles;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int ack0;
    int wv0;

    vecs[0] = '{42'h100, 16, 42'h10F, 32'd16, 40};
    vecs[1] = '{42'h3FF_FFFF_FFFE, 4, 42'h1, 32'd4, 40};
    vecs[2] = '{42'h55, 0, 42'h0, 32'd0, 3};
    vecs[3] = '{42'h3FF_FFFF_FFFF, 1, 42'h3FF_FFFF_FFFF, 32'd1, 40};

    do_reset();
    check_output("reset_ack", 64'(ack_write), 64'd0);
    check_output("reset_wr_valid", 64'(wr_valid), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_lines", 64'(lines_written), 64'd0);
    check_output("reset_wr_addr", 64'(wr_addr), 64'd0);

    // Complete runs: streaming, address wrap, empty run.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      ack0     = ack_cnt;
      wv0      = wv_cnt;
      rsp_auto = 1'b1;
      start_block(vecs[v].base);
      for (int j = 0; j < vecs[v].n_lines; j++)
        apply_stimulus(random_line(), vecs[v].base + ADDR_W'(j));
      finish = 1'b1;
      wait_done(vecs[v].max_done_cycles);
      check_output("vec_lines_written", 64'(lines_written), 64'(vecs[v].exp_lines));
      check_output("vec_last_addr", 64'(wr_addr), 64'(vecs[v].exp_last_addr));
      check_output("vec_ack_count", 64'(ack_cnt - ack0), 64'(vecs[v].n_lines));
      check_output("vec_write_count", 64'(wv_cnt - wv0), 64'(vecs[v].n_lines));
      check_output("vec_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    // Backpressure: FIFO fills to 4, producer stalls with req held.
    do_reset();
    rsp_auto       = 1'b1;
    wr_almost_full = 1'b1;
    start_block(42'h300);
    ack0 = ack_cnt;
    wv0  = wv_cnt;
    fork
      begin
        for (int j = 0; j < 6; j++) apply_stimulus(random_line(), 42'h300 + ADDR_W'(j));
      end
      begin
        repeat (50) step();
        check_output("bp_acks_while_full", 64'(ack_cnt - ack0), 64'd4);
        check_output("bp_no_writes", 64'(wv_cnt - wv0), 64'd0);
        check_output("bp_req_held", 64'(req_write), 64'd1);
        wr_almost_full = 1'b0;
      end
    join
    finish = 1'b1;
    wait_done(60);
    check_output("bp_lines_written", 64'(lines_written), 64'd6);
    check_output("bp_ack_count", 64'(ack_cnt - ack0), 64'd6);
    check_output("bp_write_count", 64'(wv_cnt - wv0), 64'd6);

    // Outstanding limit: responses withheld, then released one and two at a time.
    do_reset();
    start_block(42'h40);
    wv0 = wv_cnt;
    for (int j = 0; j < 19; j++) apply_stimulus(random_line(), 42'h40 + ADDR_W'(j));
    repeat (10) step();
    check_output("outst_cap_writes", 64'(wv_cnt - wv0), 64'd16);
    check_output("outst_cap_lines", 64'(lines_written), 64'd0);
    rsp_manual = 1'b1;
    step();
    rsp_manual = 1'b0;
    repeat (5) step();
    check_output("outst_one_rsp_writes", 64'(wv_cnt - wv0), 64'd17);
    check_output("outst_one_rsp_lines", 64'(lines_written), 64'd1);
    rsp_manual = 1'b1;
    repeat (2) step();
    rsp_manual = 1'b0;
    repeat (5) step();
    check_output("outst_two_rsp_writes", 64'(wv_cnt - wv0), 64'd19);
    check_output("outst_two_rsp_lines", 64'(lines_written), 64'd3);
    rsp_manual = 1'b1;
    repeat (16) step();
    rsp_manual = 1'b0;
    step();
    check_output("outst_drained_lines", 64'(lines_written), 64'd19);
    finish = 1'b1;
    wait_done(10);

    // Reset mid-stream with three writes outstanding.
    do_reset();
    start_block(42'h500);
    wv0 = wv_cnt;
    for (int j = 0; j < 3; j++) apply_stimulus(random_line(), 42'h500 + ADDR_W'(j));
    wait_writes(wv0 + 3, 20);
    rst = 1'b0;
    #1;
    check_output("midrst_ack", 64'(ack_write), 64'd0);
    check_output("midrst_wr_valid", 64'(wr_valid), 64'd0);
    check_output("midrst_wr_addr", 64'(wr_addr), 64'd0);
    check_output("midrst_wr_data_zero", 64'(|wr_data), 64'd0);
    check_output("midrst_done", 64'(done), 64'd0);
    exp_q.delete();
    repeat (2) step();
    rst = 1'b1;
    step();
    rsp_manual = 1'b1;
    repeat (2) step();
    rsp_manual = 1'b0;
    step();
    check_output("postrst_rsp_ignored", 64'(lines_written), 64'd0);
    rsp_auto = 1'b1;
    start_block(42'h200);
    apply_stimulus(random_line(), 42'h200);
    finish = 1'b1;
    wait_done(30);
    check_output("postrst_lines", 64'(lines_written), 64'd1);
    check_output("postrst_addr", 64'(wr_addr), 64'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
